// File: rtl/audio_pcm_serializer_pkg.sv
// Shared audio constants: frame ratio and serial format encodings plus
// decode of the reserved codes.
package audio_pcm_serializer_pkg;

    typedef enum logic [1:0] {
        RATIO_128 = 2'd0,
        RATIO_256 = 2'd1,
        RATIO_512 = 2'd2
    } ratio_e;

    typedef enum logic [1:0] {
        FMT_I2S = 2'd0,
        FMT_LJ  = 2'd1,
        FMT_RJ  = 2'd2
    } fmt_e;

    localparam int CNT_W = 9;

    // Reserved ratio code falls back to 256 MCLK per frame.
    function automatic ratio_e decode_ratio(input logic [1:0] code);
        ratio_e r;
        case (code)
            2'd0:    r = RATIO_128;
            2'd2:    r = RATIO_512;
            default: r = RATIO_256;
        endcase
        return r;
    endfunction

    // Reserved format code falls back to I2S.
    function automatic fmt_e decode_format(input logic [1:0] code);
        fmt_e f;
        case (code)
            2'd1:    f = FMT_LJ;
            2'd2:    f = FMT_RJ;
            default: f = FMT_I2S;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/audio_frame_timer.sv
// Frame counter with registered bck/lrck/frame_start; exposes the current
// half/slot so the data path can register sdata on the same edge.
module audio_frame_timer
    import audio_pcm_serializer_pkg::*;
(
    input  logic       clk_core,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] ratio,
    input  logic [1:0] format,
    output logic       half,
    output logic [4:0] slot,
    output logic       last,
    output logic       bck,
    output logic       lrck,
    output logic       frame_start
);

    logic [CNT_W-1:0] cnt;
    logic [5:0]       bit_idx;
    logic             bck_n;

    // D = R/64: the bit index is cnt/D and bck is high for the upper half of D.
    always_comb begin
        bit_idx = cnt[7:2];
        bck_n   = cnt[1];
        last    = (cnt == 9'd255);
        case (ratio)
            RATIO_128: begin
                bit_idx = cnt[6:1];
                bck_n   = cnt[0];
                last    = (cnt == 9'd127);
            end
            RATIO_512: begin
                bit_idx = cnt[8:3];
                bck_n   = cnt[2];
                last    = (cnt == 9'd511);
            end
            default: ;
        endcase
    end

    assign half = bit_idx[5];
    assign slot = bit_idx[4:0];

    always_ff @(posedge clk_core) begin
        if (reset || !enable) begin
            cnt         <= '0;
            bck         <= 1'b0;
            lrck        <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            cnt         <= last ? '0 : cnt + 9'd1;
            bck         <= bck_n;
            lrck        <= half ^ (format != FMT_I2S);
            frame_start <= (cnt == '0);
        end
    end

endmodule

// File: rtl/audio_pcm_serializer.sv
// Multi-line PCM serializer: double-buffered sample banks feeding I2S/LJ/RJ
// serial lines, timed by audio_frame_timer.
module audio_pcm_serializer
    import audio_pcm_serializer_pkg::*;
#(
    parameter int NUM_LINES   = 1,
    parameter int SAMPLE_BITS = 24
) (
    input  logic                   clk_core,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [1:0]             cfg_ratio,
    input  logic [1:0]             cfg_format,
    input  logic                   s_valid,
    input  logic [SAMPLE_BITS-1:0] s_data,
    output logic                   s_ready,
    output logic                   bck,
    output logic                   lrck,
    output logic [NUM_LINES-1:0]   sdata,
    output logic                   frame_start,
    output logic                   underrun,
    input  logic                   underrun_clr
);

    localparam int SB     = SAMPLE_BITS;
    localparam int NUM_CH = 2 * NUM_LINES;
    localparam int WP_W   = $clog2(NUM_CH);
    localparam logic [WP_W-1:0] WP_LAST = WP_W'(NUM_CH - 1);
    localparam logic [SB-1:0]   ONE     = SB'(1);

    logic   enable_q, en_rise;
    ratio_e ratio_q;
    fmt_e   fmt_q;
    logic [1:0] ratio_eff, fmt_eff;

    // Config is sampled on the enable rising cycle and used in that cycle too.
    assign en_rise   = enable && !enable_q;
    assign ratio_eff = en_rise ? decode_ratio(cfg_ratio)   : ratio_q;
    assign fmt_eff   = en_rise ? decode_format(cfg_format) : fmt_q;

    always_ff @(posedge clk_core) begin
        if (reset) begin
            enable_q <= 1'b0;
            ratio_q  <= RATIO_256;
            fmt_q    <= FMT_I2S;
        end else begin
            enable_q <= enable;
            if (en_rise) begin
                ratio_q <= decode_ratio(cfg_ratio);
                fmt_q   <= decode_format(cfg_format);
            end
        end
    end

    logic       half, last;
    logic [4:0] slot;

    audio_frame_timer u_timer (
        .clk_core    (clk_core),
        .reset       (reset),
        .enable      (enable),
        .ratio       (ratio_eff),
        .format      (fmt_eff),
        .half        (half),
        .slot        (slot),
        .last        (last),
        .bck         (bck),
        .lrck        (lrck),
        .frame_start (frame_start)
    );

    logic [NUM_CH-1:0][SB-1:0] next_bank, active_bank, next_merged;
    logic [WP_W-1:0]           wp;
    logic                      next_full, xfer, full_now, ur_set;

    assign s_ready  = enable && !next_full && !reset;
    assign xfer     = s_valid && s_ready;
    // A final sample landing on the last frame cycle still counts as full.
    assign full_now = next_full || (xfer && (wp == WP_LAST));
    assign ur_set   = enable && last && !full_now;

    always_comb begin
        next_merged = next_bank;
        if (xfer) next_merged[wp] = s_data;
    end

    always_ff @(posedge clk_core) begin
        if (reset || !enable) begin
            next_bank   <= '0;
            active_bank <= '0;
            wp          <= '0;
            next_full   <= 1'b0;
        end else if (last) begin
            if (full_now) begin
                active_bank <= next_merged;
                next_bank   <= '0;
                wp          <= '0;
                next_full   <= 1'b0;
            end else begin
                active_bank <= '0;
                next_bank   <= next_merged;
                if (xfer) wp <= wp + 1'b1;
            end
        end else begin
            next_bank <= next_merged;
            if (xfer) begin
                if (wp == WP_LAST) next_full <= 1'b1;
                else               wp        <= wp + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_core) begin
        if (reset)             underrun <= 1'b0;
        else if (ur_set)       underrun <= 1'b1;
        else if (underrun_clr) underrun <= 1'b0;
    end

    logic [5:0] msb_slot, pos, bit_sel;
    logic       in_word;

    always_comb begin
        case (fmt_eff)
            FMT_LJ:  msb_slot = 6'd0;
            FMT_RJ:  msb_slot = 6'(32 - SB);
            default: msb_slot = 6'd1;
        endcase
        pos     = {1'b0, slot} - msb_slot;
        in_word = ({1'b0, slot} >= msb_slot) && (pos < 6'(SB));
        bit_sel = 6'(SB - 1) - pos;
    end

    logic [NUM_LINES-1:0] sdata_n;

    for (genvar l = 0; l < NUM_LINES; l++) begin : g_line
        logic [SB-1:0] word;
        assign word       = half ? active_bank[2*l+1] : active_bank[2*l];
        assign sdata_n[l] = in_word && |(word & (ONE << bit_sel));
    end

    always_ff @(posedge clk_core) begin
        if (reset || !enable) sdata <= '0;
        else                  sdata <= sdata_n;
    end

endmodule

// File: tb/tb_audio_pcm_serializer.sv
// Directed bench: 1-line/24-bit instance for formats, flow control and
// underrun; 4-line/16-bit instance for multi-line channel mapping at R=128.
module tb_audio_pcm_serializer;

    logic        clk_core = 1'b0;
    always #5 clk_core = ~clk_core;

    logic        reset, en1, en4, s_valid, underrun_clr, cap_sel;
    logic [1:0]  cfg_ratio, cfg_format;
    logic [23:0] s_data;

    logic        rdy1, bck1, lrck1, fs1, ur1;
    logic [0:0]  sd1;
    logic        rdy4, bck4, lrck4, fs4, ur4;
    logic [3:0]  sd4;

    audio_pcm_serializer #(.NUM_LINES(1), .SAMPLE_BITS(24)) dut1 (
        .clk_core(clk_core), .reset(reset), .enable(en1),
        .cfg_ratio(cfg_ratio), .cfg_format(cfg_format),
        .s_valid(s_valid), .s_data(s_data), .s_ready(rdy1),
        .bck(bck1), .lrck(lrck1), .sdata(sd1), .frame_start(fs1),
        .underrun(ur1), .underrun_clr(underrun_clr)
    );

    audio_pcm_serializer #(.NUM_LINES(4), .SAMPLE_BITS(16)) dut4 (
        .clk_core(clk_core), .reset(reset), .enable(en4),
        .cfg_ratio(cfg_ratio), .cfg_format(cfg_format),
        .s_valid(s_valid), .s_data(s_data[15:0]), .s_ready(rdy4),
        .bck(bck4), .lrck(lrck4), .sdata(sd4), .frame_start(fs4),
        .underrun(ur4), .underrun_clr(underrun_clr)
    );

    logic       fs_m, bck_m, lrck_m, rdy_m;
    logic [3:0] sd_m;
    always_comb begin
        fs_m   = cap_sel ? fs4   : fs1;
        bck_m  = cap_sel ? bck4  : bck1;
        lrck_m = cap_sel ? lrck4 : lrck1;
        rdy_m  = cap_sel ? rdy4  : rdy1;
        sd_m   = cap_sel ? sd4   : {3'b000, sd1};
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [23:0] d);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        @(negedge clk_core);
        while (!rdy_m && n < 1000) begin
            @(negedge clk_core);
            n++;
        end
        check("push_ready", 32'(rdy_m), 32'd1);
        @(posedge clk_core);
        #1 s_valid = 1'b0;
    endtask

    // Records one frame from a frame_start pulse to the next; slot 0 ends at bit 31.
    task automatic capture(output logic [3:0][31:0] wl, output logic [3:0][31:0] wr,
                           output int nbck, output int len,
                           output logic lr_l, output logic lr_r);
        int   n, k;
        logic pb;
        n = 0; k = 0; wl = '0; wr = '0; len = 0; lr_l = 1'b0; lr_r = 1'b0;
        while (!fs_m && n < 1200) begin
            @(negedge clk_core);
            n++;
        end
        check("frame_start_seen", 32'(fs_m), 32'd1);
        pb = bck_m;
        do begin
            if (bck_m && !pb) begin
                if (k == 0)  lr_l = lrck_m;
                if (k == 32) lr_r = lrck_m;
                for (int l = 0; l < 4; l++) begin
                    if (k < 32)      wl[l] = {wl[l][30:0], sd_m[l]};
                    else if (k < 64) wr[l] = {wr[l][30:0], sd_m[l]};
                end
                k++;
            end
            pb = bck_m;
            len++;
            @(negedge clk_core);
        end while (!fs_m && len < 1200);
        nbck = k;
    endtask

    logic [3:0][31:0] wl, wr;
    int               nb, ln;
    logic             ll, lr;
    logic [31:0]      exp_l4 [4] = '{32'h0008_0000, 32'h0009_0000, 32'h000A_0000, 32'h000B_0000};
    logic [31:0]      exp_r4 [4] = '{32'h0008_8000, 32'h0009_8000, 32'h000A_8000, 32'h000B_8000};

    initial begin
        reset = 1'b1; en1 = 1'b0; en4 = 1'b0; s_valid = 1'b0; s_data = '0;
        underrun_clr = 1'b0; cfg_ratio = 2'd1; cfg_format = 2'd0; cap_sel = 1'b0;
        repeat (3) @(posedge clk_core);
        #1;
        check("rst_bck",  32'(bck1),  32'd0);
        check("rst_lrck", 32'(lrck1), 32'd0);
        check("rst_sdata", 32'(sd1),  32'd0);
        check("rst_fs",   32'(fs1),   32'd0);
        check("rst_ur",   32'(ur1),   32'd0);
        reset = 1'b0;
        @(posedge clk_core); #1;
        check("dis_ready", 32'(rdy1), 32'd0);

        // I2S, R=256: frame 0 plays zeros while the first pair is queued.
        en1 = 1'b1;
        fork
            capture(wl, wr, nb, ln, ll, lr);
            begin
                push(24'h800001);
                push(24'h7FFFFE);
                @(negedge clk_core);
                check("ready_low_full", 32'(rdy1), 32'd0);
            end
        join
        check("f0_left_zero",  wl[0], 32'h0);
        check("f0_right_zero", wr[0], 32'h0);
        check("f0_len",        32'(ln), 32'd256);
        check("f0_ur",         32'(ur1), 32'd0);
        check("ready_after_copy", 32'(rdy1), 32'd1);

        capture(wl, wr, nb, ln, ll, lr);
        check("i2s_left",  wl[0], 32'h4000_0080);
        check("i2s_right", wr[0], 32'h3FFF_FF00);
        check("i2s_lr_l",  32'(ll), 32'd0);
        check("i2s_lr_r",  32'(lr), 32'd1);
        check("i2s_nbck",  32'(nb), 32'd64);
        check("ur_set",    32'(ur1), 32'd1);

        capture(wl, wr, nb, ln, ll, lr);
        check("starve_left",  wl[0], 32'h0);
        check("starve_right", wr[0], 32'h0);

        // Internal cnt is 1 here; clear, then collide clear with the next set.
        underrun_clr = 1'b1;
        @(posedge clk_core); #1 underrun_clr = 1'b0;
        @(negedge clk_core);
        check("ur_cleared", 32'(ur1), 32'd0);
        repeat (253) @(negedge clk_core);
        underrun_clr = 1'b1;
        @(posedge clk_core); #1 underrun_clr = 1'b0;
        @(negedge clk_core);
        check("ur_set_wins", 32'(ur1), 32'd1);

        // Final sample accepted on cnt == R-1 still plays next frame.
        underrun_clr = 1'b1;
        @(posedge clk_core); #1 underrun_clr = 1'b0;
        push(24'h800001);
        repeat (254) @(negedge clk_core);
        s_valid = 1'b1;
        s_data  = 24'h7FFFFE;
        check("ready_at_last", 32'(rdy1), 32'd1);
        @(posedge clk_core); #1 s_valid = 1'b0;
        @(negedge clk_core);
        check("no_ur_last", 32'(ur1), 32'd0);
        capture(wl, wr, nb, ln, ll, lr);
        check("last_left",  wl[0], 32'h4000_0080);
        check("last_right", wr[0], 32'h3FFF_FF00);

        // Disable in the right half: outputs drop, underrun holds.
        repeat (150) @(negedge clk_core);
        check("pre_dis_lrck", 32'(lrck1), 32'd1);
        en1 = 1'b0;
        @(posedge clk_core); #1;
        check("dis_bck",   32'(bck1),  32'd0);
        check("dis_lrck",  32'(lrck1), 32'd0);
        check("dis_sdata", 32'(sd1),   32'd0);
        check("dis_rdy",   32'(rdy1),  32'd0);
        check("dis_ur_kept", 32'(ur1), 32'd1);

        cfg_format = 2'd1;
        en1 = 1'b1;
        fork
            capture(wl, wr, nb, ln, ll, lr);
            begin push(24'h800001); push(24'h7FFFFE); end
        join
        capture(wl, wr, nb, ln, ll, lr);
        check("lj_left",  wl[0], 32'h8000_0100);
        check("lj_right", wr[0], 32'h7FFF_FE00);
        check("lj_lr_l",  32'(ll), 32'd1);
        check("lj_lr_r",  32'(lr), 32'd0);

        en1 = 1'b0;
        @(posedge clk_core); #1;
        cfg_format = 2'd2;
        en1 = 1'b1;
        fork
            capture(wl, wr, nb, ln, ll, lr);
            begin push(24'h800001); push(24'h7FFFFE); end
        join
        capture(wl, wr, nb, ln, ll, lr);
        check("rj_left",  wl[0], 32'h0080_0001);
        check("rj_right", wr[0], 32'h007F_FFFE);
        check("rj_lr_l",  32'(ll), 32'd1);

        // Ratio change takes effect only after an enable toggle.
        cfg_ratio = 2'd0;
        capture(wl, wr, nb, ln, ll, lr);
        check("ratio_ignored_len", 32'(ln), 32'd256);
        en1 = 1'b0;
        @(posedge clk_core); #1;
        en1 = 1'b1;
        capture(wl, wr, nb, ln, ll, lr);
        check("ratio_new_len",  32'(ln), 32'd128);
        check("ratio_new_nbck", 32'(nb), 32'd64);

        // Reset mid-frame while bck is high.
        begin
            int n;
            n = 0;
            repeat (70) @(negedge clk_core);
            while (!bck1 && n < 20) begin
                @(negedge clk_core);
                n++;
            end
        end
        check("pre_rst_bck", 32'(bck1), 32'd1);
        reset = 1'b1;
        @(posedge clk_core); #1;
        check("mrst_bck",  32'(bck1),  32'd0);
        check("mrst_lrck", 32'(lrck1), 32'd0);
        check("mrst_sdata", 32'(sd1),  32'd0);
        check("mrst_fs",   32'(fs1),   32'd0);
        check("mrst_rdy",  32'(rdy1),  32'd0);
        check("mrst_ur",   32'(ur1),   32'd0);
        reset = 1'b0;
        en1   = 1'b0;

        // Four lines, 16-bit, I2S, R=128.
        @(posedge clk_core); #1;
        cap_sel    = 1'b1;
        cfg_ratio  = 2'd0;
        cfg_format = 2'd0;
        en4 = 1'b1;
        fork
            capture(wl, wr, nb, ln, ll, lr);
            begin
                for (int i = 0; i < 8; i++) push(24'(8'h10 + i));
            end
        join
        capture(wl, wr, nb, ln, ll, lr);
        for (int l = 0; l < 4; l++) begin
            check($sformatf("ml_left%0d", l),  wl[l], exp_l4[l]);
            check($sformatf("ml_right%0d", l), wr[l], exp_r4[l]);
        end
        check("ml_len",  32'(ln), 32'd128);
        check("ml_nbck", 32'(nb), 32'd64);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/audio_pcm_serializer.md
AUDIO_PCM_SERIALIZER -- requirements
Module: audio_pcm_serializer

Interface
REQ-001 Parameter NUM_LINES, default 1, meaning serial data lines; channels = 2*NUM_LINES; legal range 1..4.
REQ-002 Parameter SAMPLE_BITS, default 24, meaning sample width; legal range 16..32.
REQ-003 clk_core  input  1  sole clock, MCLK rate; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 enable  input  1  run when high; idle/flush when low.
REQ-006 cfg_ratio  input  2  0=128, 1=256, 2=512 MCLK per frame (R); 3 reserved, treated as 256.
REQ-007 cfg_format  input  2  0=I2S, 1=left-justified, 2=right-justified; 3 reserved, treated as I2S.
REQ-008 s_valid / s_data / s_ready  input 1 / input SAMPLE_BITS / output 1  sample stream, channel order 0..2*NUM_LINES-1, two's complement.
REQ-009 bck, lrck  output 1 each  serial bit clock and word clock.
REQ-010 sdata  output NUM_LINES  serial data; line l carries channel 2l (left) and 2l+1 (right).
REQ-011 frame_start  output 1  one-cycle pulse when counter wraps to 0.
REQ-012 underrun, underrun_clr  output 1 / input 1  sticky starvation flag and its clear.

Function
REQ-013 cfg_ratio and cfg_format SHALL be latched only on the cycle enable goes 0->1; changes while enabled have no effect.
REQ-014 Frame counter cnt SHALL run 0..R-1 and wrap; D = R/64 clocks per bit; bit index b = cnt/D (0..63); slot s = b mod 32.
REQ-015 bck SHALL be low for the first D/2 clocks of each bit period and high for the last D/2 (64 BCK per frame).
REQ-016 Left half is b<32; lrck SHALL be 0 for left in I2S and 1 for left in LJ/RJ.
REQ-017 Within a half, the MSB SHALL be at s=1 (I2S), s=0 (LJ), s=32-SAMPLE_BITS (RJ); following bits MSB-first; all other slots drive 0.
REQ-018 bck, lrck, sdata SHALL be registered together, so sdata changes only coincident with the bck falling edge; latency cnt->pins exactly 1 cycle.
REQ-019 Two banks: next (fill) and active (shift); fill pointer wp counts 0..2*NUM_LINES-1; next_full set when channel 2*NUM_LINES-1 is accepted.
REQ-020 s_ready SHALL equal enable && !next_full; a transfer occurs on s_valid && s_ready.
REQ-021 On cycle cnt==R-1: if next_full (including a final sample accepted that same cycle), copy next->active, clear next_full, wp=0.
REQ-022 On cycle cnt==R-1 without next_full: active SHALL load all zeros, underrun SHALL set, partially filled next bank and wp SHALL be retained.
REQ-023 underrun_clr SHALL clear underrun; a set event in the same cycle wins.
REQ-024 enable low SHALL hold cnt=0, clear both banks, wp, next_full, and drive bck, lrck, sdata, frame_start, s_ready to 0; underrun retained.
REQ-025 On enable 0->1, the first frame SHALL start at cnt=0 with active bank zero (no underrun reported for that first frame).

Reset
REQ-026 reset SHALL force cnt=0, wp=0, banks zero, next_full=0, latched config = 256/I2S, underrun=0, and every output 0.
REQ-027 reset asserted mid-frame SHALL take effect the next edge with no partial output completion.

Structure
REQ-028 Ratio and format encodings SHALL be defined in the shared audio constants include used by the slot controllers.
REQ-029 Counter, bck/lrck generation and frame_start SHALL be one sub-module, audio_frame_timer; bank and shift logic stays in the top.

Verification
REQ-030 NUM_LINES=1, 24-bit, I2S, R=256, samples 0x800001/0x7FFFFE -> lrck low half has bits 1..24 = 0x800001, high half 0x7FFFFE, 64 bck rising edges per frame.
REQ-031 Same samples, LJ and RJ -> MSB at slot 0 resp. slot 8, lrck high on left.
REQ-032 NUM_LINES=4, R=128, channels 0..7 = 0x10..0x17 -> sdata[l] carries 0x10+2l left, 0x11+2l right; D=2.
REQ-033 Stop s_valid after one frame -> next frame all zeros, underrun=1; underrun_clr pulse clears it; simultaneous set+clr leaves 1.
REQ-034 Last sample accepted on cnt==R-1 -> played next frame, underrun stays 0; s_ready low until copy.
REQ-035 Change cfg_ratio while enabled -> no effect; toggle enable -> new ratio applied, outputs 0 while low; reset mid-frame -> all outputs 0 next cycle.
